// File: rtl/truth_table_sweeper_if.sv
// Sweep control/result bundle between the sweeper and its driver/observer.
// The master drives start/expected and the circuit output; the slave walks the patterns.
interface truth_table_sweeper_if #(
  parameter int N_IN = 3
);
  localparam int NP = 1 << N_IN;

  logic            start;
  logic [NP-1:0]   expected;
  logic            dut_out;
  logic [N_IN-1:0] pattern;
  logic            busy;
  logic            done;
  logic [NP-1:0]   table_out;
  logic [N_IN:0]   mismatch_count;
  logic            pass;

  modport master (
    output start, expected, dut_out,
    input  pattern, busy, done, table_out, mismatch_count, pass
  );

  modport slave (
    input  start, expected, dut_out,
    output pattern, busy, done, table_out, mismatch_count, pass
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks all 2^N_IN input patterns, holds each HOLD clocks, samples and scores the truth table.
// busy lasts 2^N_IN*HOLD cycles then done pulses once; start is ignored (not queued) unless idle.
module truth_table_sweeper #(
  parameter int N_IN = 3,
  parameter int HOLD = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  truth_table_sweeper_if.slave  sw
);
  localparam int NP = 1 << N_IN;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_FINISH} state_t;

  state_t          r_state, w_state_nxt;
  logic [HW-1:0]   r_hold, w_hold_nxt;
  logic [N_IN-1:0] r_pattern, w_pattern_nxt;
  logic [NP-1:0]   r_exp, w_exp_nxt;
  logic [NP-1:0]   r_table, w_table_nxt;
  logic [N_IN:0]   r_mm, w_mm_nxt;
  logic            r_pass, w_pass_nxt;
  logic            w_sample;
  logic            w_miss;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_hold    <= '0;
      r_pattern <= '0;
      r_exp     <= '0;
      r_table   <= '0;
      r_mm      <= '0;
      r_pass    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_hold    <= w_hold_nxt;
      r_pattern <= w_pattern_nxt;
      r_exp     <= w_exp_nxt;
      r_table   <= w_table_nxt;
      r_mm      <= w_mm_nxt;
      r_pass    <= w_pass_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_hold_nxt    = r_hold;
    w_pattern_nxt = r_pattern;
    w_exp_nxt     = r_exp;
    w_table_nxt   = r_table;
    w_mm_nxt      = r_mm;
    w_pass_nxt    = r_pass;
    w_sample      = (r_hold == HW'(HOLD - 1));
    w_miss        = (sw.dut_out != r_exp[r_pattern]);

    case (r_state)
      S_IDLE: begin
        if (sw.start) begin
          w_exp_nxt     = sw.expected;
          w_table_nxt   = '0;
          w_mm_nxt      = '0;
          w_pass_nxt    = 1'b0;
          w_hold_nxt    = '0;
          w_pattern_nxt = '0;
          w_state_nxt   = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (!w_sample) begin
          w_hold_nxt = r_hold + HW'(1);
        end else begin
          w_hold_nxt             = '0;
          w_table_nxt[r_pattern] = sw.dut_out;
          if (w_miss) w_mm_nxt = r_mm + (N_IN + 1)'(1);
          // Last pattern leaves DRIVE, so the increment below never wraps.
          if (r_pattern == {N_IN{1'b1}}) begin
            w_state_nxt = S_FINISH;
            w_pass_nxt  = (w_mm_nxt == '0);
          end else begin
            w_pattern_nxt = r_pattern + N_IN'(1);
          end
        end
      end
      S_FINISH: begin
        w_state_nxt   = S_IDLE;
        w_pattern_nxt = '0;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign sw.pattern        = r_pattern;
  assign sw.busy           = (r_state == S_DRIVE);
  assign sw.done           = (r_state == S_FINISH);
  assign sw.table_out      = r_table;
  assign sw.mismatch_count = r_mm;
  assign sw.pass           = r_pass;
endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequential stimulus/capture stage directly upstream of our small combinational circuits (3-input, 1-output gate networks).
- Replaces hand-written per-pattern delay stimulus: on `start` it walks every input combination, holds each for a fixed number of clocks, and samples the circuit output.
- Assembles the measured truth table and compares it against an expected table.
- Reports pass/fail and the mismatch count.

Parameters:
- N_IN, 3, number of circuit inputs; pattern space is 2^N_IN.
- HOLD, 2, clocks each pattern is held before sampling (settle time); must be >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a sweep; sampled only in IDLE
- expected  input  2^N_IN  expected output; bit i = value for pattern i; latched on accepted start
- dut_out  input  1  output of the circuit under sweep (combinational, driven from `pattern`)
- pattern  output  N_IN  current input vector to the circuit; MSB = first input (a), LSB = last (c)
- busy  output  1  high while sweeping
- done  output  1  one-cycle pulse when the sweep completes
- table_out  output  2^N_IN  measured truth table; bit i = sampled dut_out for pattern i
- mismatch_count  output  N_IN+1  number of patterns whose sample differs from expected
- pass  output  1  high when the last completed sweep had zero mismatches

Behaviour:
- Reset (async, any time, including mid-sweep):
  - All outputs go to 0.
  - State = IDLE; hold counter = 0; latched expected = 0.
  - Any sweep in progress is abandoned; there is no done pulse.
- States: IDLE, DRIVE, FINISH.
- IDLE:
  - pattern = 0; busy = 0.
  - table_out, mismatch_count and pass keep the results of the last sweep.
  - start = 1 at an edge E0:
    - latch expected;
    - clear table_out and mismatch_count;
    - clear pass;
    - hold counter = 0; pattern = 0; busy = 1;
    - go to DRIVE.
- DRIVE:
  - pattern is stable for exactly HOLD clocks.
  - Each edge with hold counter < HOLD-1 increments the counter.
  - The edge with hold counter == HOLD-1 is the sample edge:
    - table_out[pattern] <= dut_out;
    - if dut_out != expected_latched[pattern], mismatch_count increments;
    - hold counter resets to 0;
    - if pattern == 2^N_IN-1, go to FINISH (pattern stays at its value); otherwise pattern increments.
- FINISH (one cycle):
  - busy = 0, done = 1.
  - pass = (mismatch_count == 0); table_out and mismatch_count are final.
  - Next edge: done <= 0, go to IDLE, pattern <= 0.
- Latency with start accepted at E0:
  - busy is high for exactly 2^N_IN × HOLD cycles.
  - done is high in the following cycle (16 + 1 cycles for the defaults).
- start while busy or in FINISH is ignored; it is not queued.
- A start held high continuously re-triggers a new sweep on the first IDLE edge after FINISH.
- pattern wraps only through FINISH → IDLE. The increment never overflows, because the last pattern exits DRIVE.
- mismatch_count is N_IN+1 bits, so an all-wrong sweep (2^N_IN) is representable without overflow.
- dut_out is sampled only on sample edges; glitches between sample edges have no effect.
- Changing `expected` mid-sweep has no effect; the value latched at start is used.

Test Plan:
- Reset → all outputs 0. Pulse start with expected=8'hEA and dut_out driven as (a&b)|c from pattern → pattern steps 0..7, each held 2 cycles; busy high 16 cycles; done pulses on cycle 17; table_out=8'hEA, mismatch_count=0, pass=1.
- Same circuit, expected=8'hE8 (bit 1 wrong) → table_out=8'hEA, mismatch_count=1, pass=0.
- dut_out tied to 0, expected=8'hFF → mismatch_count=8 (4'b1000), table_out=8'h00, pass=0.
- Assert rst while pattern=3 mid-sweep → outputs immediately 0 (asynchronous), no done pulse. A fresh start then completes a full 16-cycle sweep with correct results.
- Pulse start again at pattern=5 during a sweep, and change expected mid-sweep → no restart, sweep ends on schedule, comparison uses the originally latched expected.
- Toggle dut_out on non-sample cycles only, while holding the correct value on every sample edge → table_out unaffected, pass=1.
- HOLD=1 build → busy high 8 cycles, one pattern per clock, same results as the default build.
